fetch_stage: RTL and testbench

Instruction-fetch stage of the ARM pipeline. Holds the program counter, drives the word index into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Handles stall and branch-redirect/flush from downstream stages and keeps a count of delivered instructions.

---
 rtl/arm_defs.sv | 19 +
 rtl/pipe_reg.sv | 26 ++
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arm_defs.sv
// Shared ARM pipeline definitions: widths, PC step and the IF/ID payload.
package arm_defs;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [INSTR_W-1:0] IFID_BUBBLE_INSTR = '0;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: '0, instr: IFID_BUBBLE_INSTR, valid: 1'b0};

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, sync clear beats enable.
module pipe_reg #(
  parameter int unsigned         WIDTH   = 32,
  parameter logic [WIDTH-1:0]    RST_VAL = '0,
  parameter logic [WIDTH-1:0]    CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Reset, then clear, then load when enabled; otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= RST_VAL;
    end else if (clr_i) begin
      q_o <= CLR_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, word-indexed imem address, IF/ID capture,
// stall/redirect handling and a delivered-instruction counter.
module fetch_stage
  import arm_defs::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  // Byte span of the instruction memory; sequential PC wraps inside it
  localparam logic [ADDR_W-1:0] PC_MOD = ADDR_W'(IMEM_WORDS * PC_STEP);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_seq;
  logic              pc_en;
  ifid_t             ifid_d;
  ifid_t             ifid_q;
  logic              fetch_adv;
  logic [31:0]       fetch_count_q;

  // Next-PC selection: redirect wins over stall, else sequential with wrap
  always_comb begin
    pc_seq    = (pc_q + ADDR_W'(PC_STEP)) % PC_MOD;
    pc_d      = pc_seq;
    pc_en     = 1'b0;
    fetch_adv = 1'b0;
    ifid_d    = '{pc: pc_seq, instr: imem_instr, valid: 1'b1};
    if (branch_taken) begin
      pc_d  = branch_addr & 32'hFFFF_FFFC;
      pc_en = 1'b1;
    end else if (!freeze) begin
      pc_en     = 1'b1;
      fetch_adv = 1'b1;
    end
  end

  pipe_reg #(
    .WIDTH   (ADDR_W),
    .RST_VAL (PC_RESET),
    .CLR_VAL ('0)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pc_en),
    .clr_i (1'b0),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  pipe_reg #(
    .WIDTH   ($bits(ifid_t)),
    .RST_VAL (IFID_BUBBLE),
    .CLR_VAL (IFID_BUBBLE)
  ) u_ifid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (~freeze),
    .clr_i (branch_taken),
    .d_i   (ifid_d),
    .q_o   (ifid_q)
  );

  // Count instructions accepted into IF/ID; wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else if (fetch_adv) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign imem_addr   = {2'b00, pc_q[31:2]};
  assign pc          = pc_q;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_instr = ifid_q.instr;
  assign if_id_valid = ifid_q.valid;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:1023];
  int n_cmp = 0;
  int n_err = 0;

  fetch_stage #(
    .PC_RESET   (32'h0000_0000),
    .IMEM_WORDS (1024)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .pc           (pc),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational memory; out-of-range index reads as X so it gets noticed
  always_comb begin
    imem_instr = 32'hxxxx_xxxx;
    if (imem_addr < 32'd1024) imem_instr = mem[imem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] epc, input logic [31:0] ein,
                          input logic ev, input logic [31:0] ecnt);
    chk({tag, ".if_id_pc"},    if_id_pc,          epc);
    chk({tag, ".if_id_instr"}, if_id_instr,       ein);
    chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, ev});
    chk({tag, ".fetch_count"}, fetch_count,       ecnt);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {16'hE3A0, 16'(i)};
    rst_n        = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;

    // Reset state
    step();
    step();
    chk("rst.pc", pc, 32'h0);
    chk("rst.imem_addr", imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0, 32'd0);
    rst_n = 1'b1;

    // Three free fetches
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("free%0d.imem_addr_pre", k), imem_addr, 32'(k - 1));
      step();
      chk_ifid($sformatf("free%0d", k), 32'(4 * k), {16'hE3A0, 16'(k - 1)}, 1'b1, 32'(k));
    end
    chk("free3.pc", pc, 32'd12);

    // Freeze for three cycles while IF/ID holds mem[2]
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("frz%0d.pc", k), pc, 32'd12);
      chk_ifid($sformatf("frz%0d", k), 32'd12, 32'hE3A0_0002, 1'b1, 32'd3);
    end
    freeze = 1'b0;

    // Release: mem[3..5] follow without gap
    for (int k = 4; k <= 6; k++) begin
      step();
      chk_ifid($sformatf("rel%0d", k), 32'(4 * k), {16'hE3A0, 16'(k - 1)}, 1'b1, 32'(k));
    end
    chk("rel.imem_addr", imem_addr, 32'd6);

    // Branch to 0x40
    branch_taken = 1'b1;
    branch_addr  = 32'h0000_0040;
    step();
    branch_taken = 1'b0;
    chk("br.imem_addr", imem_addr, 32'd16);
    chk("br.pc", pc, 32'h40);
    chk_ifid("br.bubble", 32'h0, 32'h0, 1'b0, 32'd6);
    step();
    chk_ifid("br.target", 32'h44, 32'hE3A0_0010, 1'b1, 32'd7);
    chk("br.pc2", pc, 32'h44);

    // Branch and freeze together, misaligned target
    branch_taken = 1'b1;
    freeze       = 1'b1;
    branch_addr  = 32'h0000_001B;
    step();
    branch_taken = 1'b0;
    chk("brfrz.pc", pc, 32'h18);
    chk_ifid("brfrz", 32'h0, 32'h0, 1'b0, 32'd7);
    step();
    chk("brfrz.hold_pc", pc, 32'h18);
    chk_ifid("brfrz.hold", 32'h0, 32'h0, 1'b0, 32'd7);
    freeze = 1'b0;
    step();
    chk_ifid("brfrz.go", 32'h1C, 32'hE3A0_0006, 1'b1, 32'd8);

    // Wrap from the last word
    branch_taken = 1'b1;
    branch_addr  = 32'h0000_0FFC;
    step();
    branch_taken = 1'b0;
    chk("wrap.pc", pc, 32'hFFC);
    chk("wrap.imem_addr", imem_addr, 32'd1023);
    step();
    chk("wrap.pc_next", pc, 32'h0);
    chk("wrap.imem_addr_next", imem_addr, 32'h0);
    chk_ifid("wrap.last", 32'h0, 32'hE3A0_03FF, 1'b1, 32'd9);
    step();
    chk_ifid("wrap.first", 32'h4, 32'hE3A0_0000, 1'b1, 32'd10);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.pc", pc, 32'h0);
    chk("arst.imem_addr", imem_addr, 32'h0);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0, 32'd0);
    step();
    chk_ifid("arst.held", 32'h0, 32'h0, 1'b0, 32'd0);
    rst_n = 1'b1;
    step();
    chk_ifid("arst.first", 32'h4, 32'hE3A0_0000, 1'b1, 32'd1);
    chk("arst.pc_after", pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
